multicycle_control_fsm: RTL

//  Multi-cycle successor to the single-cycle opcode decoder. Sequences each instruction through

---
 rtl/multicycle_control_fsm.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with imem/dmem handshakes,
// per-unit clock-gate enables, retired-instruction counter and a sticky trap flag.
module multicycle_control_fsm #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter bit ENABLE_JAL  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero_flag,
    input  logic             stall_i,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             trap_clr,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       mem_to_reg,
    output logic             cg_en_alu,
    output logic             cg_en_rf,
    output logic             cg_en_dmem,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state_o
);
    // state  | meaning
    // FETCH  | imem request outstanding, IR/PC load on imem_ready
    // DECODE | latch opcode, read operands, screen illegal opcodes
    // EXEC   | ALU operation; branches resolve and retire here
    // MEM    | dmem request outstanding (LW/SW)
    // WB     | register write-back, JAL PC update
    // TRAP   | sticky illegal/timeout state, left only via trap_clr
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       br_pc;
        logic       wb_pc;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic       cg_alu;
        logic       cg_rf;
        logic       cg_dmem;
        logic       illegal;
    } ctrl_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam int            TO_W   = $clog2(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT - 1);

    function automatic logic is_legal(input logic [6:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_LUI: ok = 1'b1;
            OP_JAL:                                  ok = ENABLE_JAL;
            default:                                 ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic ctrl_t decode(input state_t s, input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH:  c.imem_req = 1'b1;
            ST_DECODE: c.cg_rf = 1'b1;
            ST_EXEC: begin
                c.cg_alu = 1'b1;
                case (op)
                    OP_R:         c.alu_op = 2'b10;
                    OP_I:         begin c.alu_src_b = 1'b1; c.alu_op = 2'b10; end
                    OP_LW, OP_SW: c.alu_src_b = 1'b1;
                    OP_BR:        begin c.alu_op = 2'b01; c.br_pc = 1'b1; c.pc_src = 2'b01; end
                    OP_LUI:       begin c.alu_src_b = 1'b1; c.alu_op = 2'b11; end
                    default:      c.alu_op = 2'b00;
                endcase
            end
            ST_MEM: begin
                c.dmem_req  = 1'b1;
                c.cg_dmem   = 1'b1;
                c.mem_read  = (op == OP_LW);
                c.mem_write = (op == OP_SW);
            end
            ST_WB: begin
                c.reg_write = 1'b1;
                c.cg_rf     = 1'b1;
                if (op == OP_LW) c.mem_to_reg = 2'b01;
                if (op == OP_JAL) begin
                    c.mem_to_reg = 2'b10;
                    c.wb_pc      = 1'b1;
                    c.pc_src     = 2'b10;
                end
            end
            ST_TRAP: c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t           state_q, state_d;
    logic [6:0]       opc_q, opc_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    ctrl_t            ctrl_q;

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        to_d      = to_q;
        instret_d = instret_q;
        if (!stall_i) begin
            case (state_q)
                ST_FETCH: begin
                    // The cycle straight out of reset has no request yet, so it neither waits nor hands off.
                    if (ctrl_q.imem_req) begin
                        if (imem_ready)          state_d = ST_DECODE;
                        else if (to_q == TO_LIM) state_d = ST_TRAP;
                        else                     to_d    = to_q + 1'b1;
                    end
                end
                ST_DECODE: begin
                    opc_d   = opcode;
                    state_d = is_legal(opcode) ? ST_EXEC : ST_TRAP;
                end
                ST_EXEC: begin
                    case (opc_q)
                        OP_LW, OP_SW: state_d = ST_MEM;
                        OP_BR: begin
                            state_d   = ST_FETCH;
                            instret_d = instret_q + 1'b1;
                        end
                        default:      state_d = ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        if (opc_q == OP_LW) begin
                            state_d = ST_WB;
                        end else begin
                            state_d   = ST_FETCH;
                            instret_d = instret_q + 1'b1;
                        end
                    end else if (to_q == TO_LIM) begin
                        state_d = ST_TRAP;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
                ST_WB: begin
                    state_d   = ST_FETCH;
                    instret_d = instret_q + 1'b1;
                end
                ST_TRAP: if (trap_clr) state_d = ST_FETCH;
                default: state_d = ST_FETCH;
            endcase
            if (state_d != state_q) to_d = '0;
        end
    end

    // Controls are registered from the next state so they line up with state_q and reset to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            opc_q     <= '0;
            to_q      <= '0;
            instret_q <= '0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            to_q      <= to_d;
            instret_q <= instret_d;
            if (!stall_i) ctrl_q <= decode(state_d, opc_d);
        end
    end

    assign imem_req      = ctrl_q.imem_req;
    assign dmem_req      = ctrl_q.dmem_req;
    assign ir_write      = ctrl_q.imem_req & imem_ready & ~stall_i;
    assign pc_write      = ~stall_i & ((ctrl_q.imem_req & imem_ready) |
                                       (ctrl_q.br_pc & zero_flag) | ctrl_q.wb_pc);
    assign pc_src        = ctrl_q.pc_src;
    assign reg_write     = ctrl_q.reg_write & ~stall_i;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign cg_en_alu     = ctrl_q.cg_alu & ~stall_i;
    assign cg_en_rf      = ctrl_q.cg_rf & ~stall_i;
    assign cg_en_dmem    = ctrl_q.cg_dmem & ~stall_i;
    assign illegal_instr = ctrl_q.illegal;
    assign instret       = instret_q;
    assign state_o       = state_q;

endmodule
